// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor sequencer.
// State encoding, configuration/read command tables, power-wait widths.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG_WR,
        CFG_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        COMMIT
    } state_t;

    localparam logic [15:0] CFG [0:3] = '{
        16'h0D02, 16'h1053, 16'h1150, 16'h1460
    };

    localparam logic [15:0] RD [0:3] = '{
        16'hA200, 16'hA300, 16'hA800, 16'hA900
    };

    localparam int PWR_W      = 16;
    localparam int PWR_W_FAST = 9;

endpackage

// File: rtl/int_synch.sv
// Two-flop synchronizer for the sensor data-ready line,
// followed by a rising-edge detector on the synced level.
module int_synch (
    input  logic clk,
    input  logic rst_n,
    input  logic INT,
    output logic int_rise
);

    logic s1, s2, s3;

    // Metastability filter plus one delayed copy for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= INT;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign int_rise = s2 & ~s3;

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor transaction sequencer: power-up wait, config writes,
// 4-read data fetch per interrupt. Optional macro: INERT_TIMEOUT_EN.
module inert_seq
    import inert_pkg::*;
#(
    parameter int FAST_SIM = 0,
    parameter int TO_W     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch,
    output logic [15:0] AZ,
    output logic        vld,
    output logic        init_done,
    output logic        err
);

    state_t           state;
    logic [1:0]       idx;
    logic [PWR_W-1:0] pwr_cnt;
    logic             pwr_done;
    logic             pend;
    logic             int_rise;
    logic [7:0]       ptch_l, ptch_h, az_l, az_h;
    logic             unused_hi;

    assign unused_hi = ^rd_data[15:8];

    assign pwr_done = (FAST_SIM != 0) ? &pwr_cnt[PWR_W_FAST-1:0]
                                      : &pwr_cnt;

    int_synch u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .INT      (INT),
        .int_rise (int_rise)
    );

`ifdef INERT_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    logic            to_hit;

    assign to_hit = &to_cnt;
    assign err    = err_q;

    // Done watchdog: restarts with each issue, runs while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == CFG_WR || state == RD_ISSUE) begin
            to_cnt <= '0;
        end else if (state == CFG_WAIT || state == RD_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    // Sequencer FSM; wrt/cmd/vld/ptch/AZ are all registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            idx       <= 2'd0;
            pwr_cnt   <= '0;
            pend      <= 1'b0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            ptch      <= 16'h0000;
            AZ        <= 16'h0000;
            vld       <= 1'b0;
            init_done <= 1'b0;
            ptch_l    <= 8'h00;
            ptch_h    <= 8'h00;
            az_l      <= 8'h00;
            az_h      <= 8'h00;
`ifdef INERT_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            wrt  <= 1'b0;
            vld  <= 1'b0;
            pend <= pend | (int_rise & init_done);
            unique case (state)
                PWR_WAIT: begin
                    if (pwr_done) begin
                        state <= CFG_WR;
                        idx   <= 2'd0;
                        wrt   <= 1'b1;
                        cmd   <= CFG[0];
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                CFG_WR: state <= CFG_WAIT;
                CFG_WAIT: begin
                    if (done) begin
                        if (idx == 2'd3) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= CFG_WR;
                            wrt   <= 1'b1;
                            cmd   <= CFG[idx + 2'd1];
                        end
                    end
`ifdef INERT_TIMEOUT_EN
                    else if (to_hit) begin
                        err_q <= 1'b1;
                        idx   <= 2'd0;
                        state <= CFG_WR;
                        wrt   <= 1'b1;
                        cmd   <= CFG[0];
                    end
`endif
                end
                IDLE: begin
                    if (pend) begin
                        pend  <= int_rise;
                        idx   <= 2'd0;
                        state <= RD_ISSUE;
                        wrt   <= 1'b1;
                        cmd   <= RD[0];
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    if (done) begin
                        unique case (idx)
                            2'd0: ptch_l <= rd_data[7:0];
                            2'd1: ptch_h <= rd_data[7:0];
                            2'd2: az_l   <= rd_data[7:0];
                            2'd3: az_h   <= rd_data[7:0];
                        endcase
                        if (idx == 2'd3) begin
                            state <= COMMIT;
                        end else begin
                            idx   <= idx + 2'd1;
                            state <= RD_ISSUE;
                            wrt   <= 1'b1;
                            cmd   <= RD[idx + 2'd1];
                        end
                    end
`ifdef INERT_TIMEOUT_EN
                    else if (to_hit) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end
`endif
                end
                COMMIT: begin
                    ptch  <= {ptch_h, ptch_l};
                    AZ    <= {az_h, az_l};
                    vld   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule
